dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache controller between the MEM stage and the off-chip data memory.
- It is the producer of the pipeline stall: it asserts cpu_stall_o on a miss, and the PC, pipeline registers and hazard logic consume that signal.
- Holds the tag, valid, dirty and data arrays.
- Runs a multi-cycle req/ack handshake with memory for write-back and refill.

---
 rtl/dcache_pkg.sv | 35 +++
 rtl/dcache_sram.sv | 67 ++++++
 rtl/dcache_ctrl.sv | 174 +++++++++++++++++
 tb/tb_dcache_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared definitions for the data cache controller.
//   - FSM state encoding (IDLE / WRITEBACK / REFILL)
//   - address field widths and the default geometry
//   - address slice helpers; callers zero-extend the address to ADDR_MAX_W
//     and size-cast the result to their own field width.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } state_e;

    localparam int OFFSET_W      = 5;   // 32-byte line
    localparam int WORD_SEL_W    = 3;   // 8 words per line
    localparam int WORD_W        = 32;
    localparam int DEF_NUM_LINES = 16;
    localparam int DEF_INDEX_W   = $clog2(DEF_NUM_LINES);
    localparam int ADDR_MAX_W    = 64;

    function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [ADDR_MAX_W-1:0] addr);
        return addr[OFFSET_W-1:2];
    endfunction

    function automatic logic [ADDR_MAX_W-1:0] addr_index(input logic [ADDR_MAX_W-1:0] addr,
                                                         input int index_w);
        return (addr >> OFFSET_W) & ((64'd1 << index_w) - 64'd1);
    endfunction

    function automatic logic [ADDR_MAX_W-1:0] addr_tag(input logic [ADDR_MAX_W-1:0] addr,
                                                       input int index_w);
        return addr >> (OFFSET_W + index_w);
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: tag / valid / dirty / data storage for the direct-mapped cache.
// Asynchronous read at idx_i, synchronous writes at idx_i.
// Ports:
//   clk_i, rst_i             clock, async active-high reset (clears valid/dirty only)
//   idx_i                    line index for read and write
//   tag_o/valid_o/dirty_o    selected line status
//   line_o                   selected line data
//   word_we_i/word_sel_i/word_i   store-hit word write; marks the line dirty
//   fill_we_i/fill_tag_i/fill_line_i  refill: whole line + tag, valid=1, dirty=0
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = DEF_NUM_LINES,
    parameter int INDEX_W   = DEF_INDEX_W,
    parameter int TAG_W     = 23,
    parameter int LINE_W    = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INDEX_W-1:0]    idx_i,
    output logic [TAG_W-1:0]      tag_o,
    output logic                  valid_o,
    output logic                  dirty_o,
    output logic [LINE_W-1:0]     line_o,
    input  logic                  word_we_i,
    input  logic [WORD_SEL_W-1:0] word_sel_i,
    input  logic [WORD_W-1:0]     word_i,
    input  logic                  fill_we_i,
    input  logic [TAG_W-1:0]      fill_tag_i,
    input  logic [LINE_W-1:0]     fill_line_i
);

    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;

    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];
    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];

    // Status bits: the only state touched by reset, so a reset drops every
    // line (dirty contents included) without any write-back.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset.
    always_ff @(posedge clk_i) begin
        if (fill_we_i) begin
            tag_q[idx_i]  <= fill_tag_i;
            data_q[idx_i] <= fill_line_i;
        end else if (word_we_i) begin
            data_q[idx_i][{word_sel_i, 5'b0} +: WORD_W] <= word_i;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller
// sitting between the MEM stage and off-chip data memory.
// Optional macro DCACHE_PERF_CNT_EN adds saturating hit/miss counters.
// Ports:
//   clk_i, rst_i        clock, async active-high reset
//   cpu_req_i/we_i      MEM-stage access valid / store
//   cpu_addr_i/wdata_i  word-aligned byte address / store data
//   cpu_rdata_o         load data (zero-latency on a hit)
//   cpu_stall_o         pipeline freeze while a miss is serviced
//   mem_req_o/we_o      line request / 1 = write-back, 0 = fetch
//   mem_addr_o          line-aligned address
//   mem_wdata_o         victim line during write-back
//   mem_rdata_i         refill line, valid with mem_ack_i
//   mem_ack_i           single-cycle completion pulse
//   hit_cnt_o/miss_cnt_o  (DCACHE_PERF_CNT_EN only) performance counters
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = DEF_NUM_LINES,
    parameter int LINE_W    = 256,
    parameter int ADDR_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int INDEX_W = $clog2(NUM_LINES);
    localparam int TAG_W   = ADDR_W - OFFSET_W - INDEX_W;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     miss_addr_q;
    logic [INDEX_W-1:0]    cpu_idx, miss_idx, arr_idx;
    logic [TAG_W-1:0]      cpu_tag, miss_tag, arr_tag;
    logic [WORD_SEL_W-1:0] cpu_word;
    logic                  arr_valid, arr_dirty;
    logic [LINE_W-1:0]     arr_line;
    logic                  lookup, hit, miss;
    logic                  word_we, fill_we;

    assign cpu_idx  = INDEX_W'(addr_index(ADDR_MAX_W'(cpu_addr_i), INDEX_W));
    assign cpu_tag  = TAG_W'(addr_tag(ADDR_MAX_W'(cpu_addr_i), INDEX_W));
    assign cpu_word = addr_word(ADDR_MAX_W'(cpu_addr_i));
    assign miss_idx = INDEX_W'(addr_index(ADDR_MAX_W'(miss_addr_q), INDEX_W));
    assign miss_tag = TAG_W'(addr_tag(ADDR_MAX_W'(miss_addr_q), INDEX_W));

    // The miss is serviced from the latched address, so the transaction
    // still completes and installs the right line if the CPU drops its
    // request mid-miss.
    assign arr_idx = (state_q == IDLE) ? cpu_idx : miss_idx;

    dcache_sram #(
        .NUM_LINES (NUM_LINES),
        .INDEX_W   (INDEX_W),
        .TAG_W     (TAG_W),
        .LINE_W    (LINE_W)
    ) u_sram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .idx_i       (arr_idx),
        .tag_o       (arr_tag),
        .valid_o     (arr_valid),
        .dirty_o     (arr_dirty),
        .line_o      (arr_line),
        .word_we_i   (word_we),
        .word_sel_i  (cpu_word),
        .word_i      (cpu_wdata_i),
        .fill_we_i   (fill_we),
        .fill_tag_i  (miss_tag),
        .fill_line_i (mem_rdata_i)
    );

    assign lookup = (state_q == IDLE) && cpu_req_i;
    assign hit    = arr_valid && (arr_tag == cpu_tag);
    assign miss   = lookup && !hit;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     miss_addr_q <= '0;
        else if (miss) miss_addr_q <= cpu_addr_i;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (miss) state_d = (arr_valid && arr_dirty) ? WRITEBACK : REFILL;
            WRITEBACK: if (mem_ack_i) state_d = REFILL;
            REFILL:    if (mem_ack_i) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        cpu_stall_o = 1'b0;
        cpu_rdata_o = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        word_we     = 1'b0;
        fill_we     = 1'b0;
        unique case (state_q)
            IDLE: begin
                cpu_stall_o = miss;
                if (lookup && hit && !cpu_we_i) cpu_rdata_o = arr_line[{cpu_word, 5'b0} +: 32];
                word_we = lookup && hit && cpu_we_i;
            end
            WRITEBACK: begin
                // Array is untouched during write-back, so victim tag/line
                // read straight from it are stable until the ack.
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {arr_tag, miss_idx, {OFFSET_W{1'b0}}};
                mem_wdata_o = arr_line;
            end
            REFILL: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_addr_o  = {miss_tag, miss_idx, {OFFSET_W{1'b0}}};
                fill_we     = mem_ack_i;
            end
            default: ;
        endcase
    end

`ifdef DCACHE_PERF_CNT_EN
    logic        refill_done_q;
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // The first IDLE cycle after a refill is the replay of the missed
    // access; it must not count as a hit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            refill_done_q <= 1'b0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
        end else begin
            refill_done_q <= (state_q == REFILL) && mem_ack_i;
            if (lookup && hit && !refill_done_q && (hit_cnt_q != 32'hFFFF_FFFF))
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if (miss && (miss_cnt_q != 32'hFFFF_FFFF))
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: self-checking bench for dcache_ctrl. A behavioural memory
// answers line requests after a programmable delay; a word-level shadow of
// architectural memory produces expected load data, queued at issue and
// popped when the load completes.
module tb_dcache_ctrl;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              cpu_req_i, cpu_we_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [31:0]       cpu_wdata_i, cpu_rdata_o;
    logic              cpu_stall_o, mem_req_o, mem_we_o, mem_ack_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_wdata_o, mem_rdata_i;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]       hit_cnt_o, miss_cnt_o;
`endif

    dcache_ctrl #(.NUM_LINES(16), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .hit_cnt_o   (hit_cnt_o),
        .miss_cnt_o  (miss_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0]       exp_q [$];
    logic [31:0]       shadow [logic [31:0]];
    logic [LINE_W-1:0] mem_model [logic [31:0]];

    int                ack_delay = 3;
    logic              stray_ack = 1'b0;
    int                stab_err  = 0;
    logic              txn_we_log    [$];
    logic [31:0]       txn_addr_log  [$];
    logic [LINE_W-1:0] txn_wdata_log [$];

    function automatic logic [31:0] pat(input logic [31:0] a);
        if (a == 32'h40) return 32'h1111_2222;
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] shadow_rd(input logic [31:0] a);
        if (shadow.exists(a)) return shadow[a];
        return pat(a);
    endfunction

    function automatic logic [LINE_W-1:0] read_line(input logic [31:0] base);
        logic [LINE_W-1:0] l;
        if (mem_model.exists(base)) return mem_model[base];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = pat(base + 32'(w * 4));
        return l;
    endfunction

    function automatic logic [LINE_W-1:0] shadow_line(input logic [31:0] base);
        logic [LINE_W-1:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = shadow_rd(base + 32'(w * 4));
        return l;
    endfunction

    // Memory responder: counts cycles of an outstanding request, acks after
    // ack_delay further cycles, logs each transaction and checks that the
    // request stays stable until acknowledged.
    initial begin : mem_responder
        int          cnt;
        logic [31:0] a0;
        logic        we0;
        cnt = 0;
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            if (mem_ack_i) begin
                mem_ack_i = 1'b0;
                cnt = 0;
            end
            if (stray_ack) begin
                mem_ack_i = 1'b1;
                stray_ack = 1'b0;
            end else if (!mem_req_o) begin
                cnt = 0;
            end else begin
                if (cnt == 0) begin
                    a0 = mem_addr_o;
                    we0 = mem_we_o;
                    txn_we_log.push_back(mem_we_o);
                    txn_addr_log.push_back(mem_addr_o);
                    txn_wdata_log.push_back(mem_wdata_o);
                end else if (mem_addr_o !== a0 || mem_we_o !== we0) begin
                    stab_err++;
                end
                if (cnt == ack_delay) begin
                    mem_ack_i = 1'b1;
                    if (mem_we_o) mem_model[mem_addr_o] = mem_wdata_o;
                    else          mem_rdata_i = read_line(mem_addr_o);
                end
                cnt++;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One CPU access; holds inputs while stalled. Returns stall cycles.
    task automatic do_access(input logic we, input logic [31:0] addr,
                             input logic [31:0] wd, output int stalls);
        logic [31:0] exp;
        int guard;
        stalls = 0;
        guard = 0;
        @(negedge clk_i);
        cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wd;
        if (we) shadow[addr] = wd;
        else    exp_q.push_back(shadow_rd(addr));
        #1;
        while (cpu_stall_o === 1'b1 && guard < 200) begin
            stalls++; guard++;
            @(negedge clk_i); #1;
        end
        if (guard >= 200) begin
            n_tests++; n_fail++;
            $display("FAIL access_timeout addr=%h: stall never released", addr);
            if (!we) exp = exp_q.pop_front();
        end else if (!we) begin
            exp = exp_q.pop_front();
            n_tests++;
            if (cpu_rdata_o !== exp) begin
                n_fail++;
                $display("FAIL load_data addr=%h: got %h expected %h", addr, cpu_rdata_o, exp);
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk_i);
        cpu_req_i = 1'b0; cpu_we_i = 1'b0;
        repeat (n) @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0;
        cpu_addr_i = '0; cpu_wdata_i = '0;
        repeat (2) @(negedge clk_i);
        #1;
        n_tests++; if (mem_req_o !== 1'b0)   begin n_fail++; $display("FAIL rst_mem_req: got %b expected 0", mem_req_o); end
        n_tests++; if (mem_we_o !== 1'b0)    begin n_fail++; $display("FAIL rst_mem_we: got %b expected 0", mem_we_o); end
        n_tests++; if (cpu_stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b expected 0", cpu_stall_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        n_tests++; if (mem_addr_o !== '0)    begin n_fail++; $display("FAIL idle_mem_addr: got %h expected 0", mem_addr_o); end
        n_tests++; if (mem_wdata_o !== '0)   begin n_fail++; $display("FAIL idle_mem_wdata: got %h expected 0", mem_wdata_o); end
        n_tests++; if (cpu_rdata_o !== '0)   begin n_fail++; $display("FAIL idle_rdata: got %h expected 0", cpu_rdata_o); end
    endtask

    task automatic test_clean_miss();
        int st, n0;
        ack_delay = 3;
        n0 = txn_addr_log.size();
        do_access(1'b0, 32'h40, '0, st);
        n_tests++; if (st != 5) begin n_fail++; $display("FAIL clean_miss_stall: got %0d cycles expected 5", st); end
        n_tests++;
        if (txn_addr_log.size() != n0 + 1 || txn_addr_log[n0] !== 32'h40 || txn_we_log[n0] !== 1'b0) begin
            n_fail++; $display("FAIL clean_miss_txn: got %0d new txns expected 1 fetch of 00000040", txn_addr_log.size() - n0);
        end
        do_access(1'b0, 32'h40, '0, st);
        n_tests++; if (st != 0) begin n_fail++; $display("FAIL repeat_hit_stall: got %0d expected 0", st); end
    endtask

    task automatic test_store_hit();
        int st, n0;
        n0 = txn_addr_log.size();
        do_access(1'b1, 32'h44, 32'hDEAD_BEEF, st);
        n_tests++; if (st != 0) begin n_fail++; $display("FAIL store_hit_stall: got %0d expected 0", st); end
        do_access(1'b0, 32'h44, '0, st);
        n_tests++; if (st != 0) begin n_fail++; $display("FAIL load_after_store_stall: got %0d expected 0", st); end
        n_tests++; if (txn_addr_log.size() != n0) begin n_fail++; $display("FAIL store_hit_txn: got %0d new txns expected 0", txn_addr_log.size() - n0); end
    endtask

    task automatic test_stray_ack();
        int st;
        idle(1);
        stray_ack = 1'b1;
        repeat (2) begin
            @(negedge clk_i); #1;
            n_tests++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL stray_ack_req: got %b expected 0", mem_req_o); end
        end
        do_access(1'b0, 32'h44, '0, st);
        n_tests++; if (st != 0) begin n_fail++; $display("FAIL stray_ack_hit: got %0d stalls expected 0", st); end
    endtask

    task automatic test_dirty_miss();
        int st, n0;
        logic [LINE_W-1:0] vline;
        ack_delay = 2;
        vline = shadow_line(32'h40);
        n0 = txn_addr_log.size();
        do_access(1'b0, 32'h240, '0, st);
        n_tests++; if (st != 7) begin n_fail++; $display("FAIL dirty_miss_stall: got %0d expected 7", st); end
        n_tests++;
        if (txn_addr_log.size() != n0 + 2) begin
            n_fail++; $display("FAIL dirty_miss_txn_count: got %0d expected 2", txn_addr_log.size() - n0);
        end else begin
            if (txn_we_log[n0] !== 1'b1 || txn_addr_log[n0] !== 32'h40) begin
                n_fail++; $display("FAIL wb_addr: got we=%b addr=%h expected we=1 addr=00000040", txn_we_log[n0], txn_addr_log[n0]);
            end
            n_tests++;
            if (txn_wdata_log[n0] !== vline) begin
                n_fail++; $display("FAIL wb_line: got %h expected %h", txn_wdata_log[n0], vline);
            end
            n_tests++;
            if (txn_we_log[n0+1] !== 1'b0 || txn_addr_log[n0+1] !== 32'h240) begin
                n_fail++; $display("FAIL refill_addr: got we=%b addr=%h expected we=0 addr=00000240", txn_we_log[n0+1], txn_addr_log[n0+1]);
            end
        end
    endtask

    task automatic test_ack_latency();
        int st, n0;
        ack_delay = 0;
        n0 = txn_addr_log.size();
        do_access(1'b0, 32'h80, '0, st);
        n_tests++; if (st != 2) begin n_fail++; $display("FAIL ack0_stall: got %0d expected 2", st); end
        n_tests++; if (txn_addr_log.size() != n0 + 1) begin n_fail++; $display("FAIL ack0_txn: got %0d expected 1", txn_addr_log.size() - n0); end
        ack_delay = 10;
        n0 = txn_addr_log.size();
        do_access(1'b0, 32'hC4, '0, st);
        n_tests++; if (st != 12) begin n_fail++; $display("FAIL ack10_stall: got %0d expected 12", st); end
        n_tests++; if (txn_addr_log.size() != n0 + 1) begin n_fail++; $display("FAIL ack10_txn: got %0d expected 1", txn_addr_log.size() - n0); end
        do_access(1'b1, 32'h8C, 32'hCAFE_F00D, st);
        ack_delay = 0;
        n0 = txn_addr_log.size();
        do_access(1'b0, 32'h288, '0, st);
        n_tests++; if (st != 3) begin n_fail++; $display("FAIL ack0_dirty_stall: got %0d expected 3", st); end
        n_tests++; if (txn_addr_log.size() != n0 + 2) begin n_fail++; $display("FAIL ack0_dirty_txn: got %0d expected 2", txn_addr_log.size() - n0); end
        do_access(1'b0, 32'h8C, '0, st);   // refetched from written-back line
        n_tests++; if (stab_err != 0) begin n_fail++; $display("FAIL mem_stability: got %0d unstable cycles expected 0", stab_err); end
    endtask

    task automatic test_req_drop();
        int st, guard;
        ack_delay = 5;
        @(negedge clk_i);
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h148;
        repeat (3) @(negedge clk_i);
        cpu_req_i = 1'b0;
        guard = 0;
        #1;
        while (mem_req_o === 1'b1 && guard < 50) begin guard++; @(negedge clk_i); #1; end
        n_tests++; if (guard >= 50) begin n_fail++; $display("FAIL req_drop_timeout: mem_req_o still 1"); end
        do_access(1'b0, 32'h148, '0, st);
        n_tests++; if (st != 0) begin n_fail++; $display("FAIL req_drop_installed: got %0d stalls expected 0", st); end
    endtask

    task automatic test_reset_mid_refill();
        int st;
        ack_delay = 20;
        @(negedge clk_i);
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h100;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1; cpu_req_i = 1'b0;
        #1;
        n_tests++; if (mem_req_o !== 1'b0)   begin n_fail++; $display("FAIL midrst_mem_req: got %b expected 0", mem_req_o); end
        n_tests++; if (cpu_stall_o !== 1'b0) begin n_fail++; $display("FAIL midrst_stall: got %b expected 0", cpu_stall_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        ack_delay = 3;
        do_access(1'b0, 32'h40, '0, st);
        n_tests++; if (st != 5) begin n_fail++; $display("FAIL post_rst_miss: got %0d stalls expected 5", st); end
        do_access(1'b0, 32'h44, '0, st);
        n_tests++; if (st != 0) begin n_fail++; $display("FAIL post_rst_hit: got %0d stalls expected 0", st); end
    endtask

`ifdef DCACHE_PERF_CNT_EN
    task automatic test_perf();
        int st;
        logic [31:0] h0, m0;
        ack_delay = 1;
        idle(1);
        h0 = hit_cnt_o; m0 = miss_cnt_o;
        do_access(1'b0, 32'h40, '0, st);
        do_access(1'b0, 32'h44, '0, st);
        do_access(1'b1, 32'h48, 32'h0BAD_F00D, st);
        do_access(1'b0, 32'h300, '0, st);
        do_access(1'b0, 32'h344, '0, st);
        idle(1); #1;
        n_tests++; if (hit_cnt_o - h0 !== 32'd3)  begin n_fail++; $display("FAIL perf_hits: got %0d expected 3", hit_cnt_o - h0); end
        n_tests++; if (miss_cnt_o - m0 !== 32'd2) begin n_fail++; $display("FAIL perf_misses: got %0d expected 2", miss_cnt_o - m0); end
        dut.hit_cnt_q = 32'hFFFF_FFFE;
        do_access(1'b0, 32'h40, '0, st);
        do_access(1'b0, 32'h40, '0, st);
        do_access(1'b0, 32'h40, '0, st);
        idle(1); #1;
        n_tests++; if (hit_cnt_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL perf_saturate: got %h expected ffffffff", hit_cnt_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_miss();
        test_store_hit();
        test_stray_ack();
        test_dirty_miss();
        test_ack_latency();
        test_req_drop();
        test_reset_mid_refill();
`ifdef DCACHE_PERF_CNT_EN
        test_perf();
`endif
        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
